ll_tx_src: RTL and testbench

//  LocalLink frame source: the DMA-side transmitter feeding a compression/copy unit's TX port.

---
 rtl/ll_tx_src.sv | 224 ++++++++++++++++++++++
 tb/tb_ll_tx_src.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ll_tx_src.sv
// LocalLink frame source: turns one (flag, byte length) command plus a payload
// word stream into an 8-word header followed by the payload, with LL framing.
module ll_tx_src #(
    parameter int LEN_W = 16
) (
    input  logic             CPMDMALLCLK,
    input  logic             DMALLRSTENGINEACK,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_flag,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [31:0]      DMALLTXD,
    output logic [3:0]       DMALLTXREM,
    output logic             DMALLTXSOFN,
    output logic             DMALLTXEOFN,
    output logic             DMALLTXSOPN,
    output logic             DMALLTXEOPN,
    output logic             DMALLTXSRCRDYN,
    input  logic             LLDMATXDSTRDYN,
    output logic             busy,
    output logic             frame_done,
    output logic             len_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_PAYLOAD
    } state_t;

    localparam logic [3:0] HDR_WORDS = 4'd8;

    state_t            state_q, state_d;
    logic [3:0]        hdr_cnt_q, hdr_cnt_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              first_q, first_d;
    logic [31:0]       flag_q, flag_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       txd_q, txd_d;
    logic [3:0]        rem_q, rem_d;
    logic              sofn_q, sofn_d;
    logic              eofn_q, eofn_d;
    logic              sopn_q, sopn_d;
    logic              eopn_q, eopn_d;
    logic              srcrdyn_q, srcrdyn_d;
    logic              frame_done_q, frame_done_d;
    logic              len_err_q, len_err_d;

    logic rst;
    logic load;
    logic beat;
    logic cmd_acc;
    logic pl_acc;
    logic last_word;

    function automatic logic [LEN_W-1:0] words_of(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(3);
        return LEN_W'(sum >> 2);
    endfunction

    // Active-low byte enables for the final word; a full word is 0000.
    function automatic logic [3:0] rem_of(input logic [1:0] tail);
        case (tail)
            2'd1:    return 4'b0111;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] hdr_word(input logic [3:0] idx,
                                             input logic [31:0] flag,
                                             input logic [LEN_W-1:0] len);
        case (idx)
            4'd4:    return flag;
            4'd5:    return {{(32-LEN_W){1'b0}}, len};
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign rst       = DMALLRSTENGINEACK;
    // The output register may take a new word when it is empty or its beat is leaving.
    assign load      = srcrdyn_q | ~LLDMATXDSTRDYN;
    assign beat      = ~srcrdyn_q & ~LLDMATXDSTRDYN;
    assign cmd_ready = (state_q == S_IDLE) & ~rst;
    assign pl_ready  = (state_q == S_PAYLOAD) & load & (words_q != '0) & ~rst;
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign pl_acc    = pl_valid & pl_ready;
    assign last_word = (words_q == LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        words_d      = words_q;
        first_d      = first_q;
        flag_d       = flag_q;
        len_d        = len_q;
        txd_d        = txd_q;
        rem_d        = rem_q;
        sofn_d       = sofn_q;
        eofn_d       = eofn_q;
        sopn_d       = sopn_q;
        eopn_d       = eopn_q;
        srcrdyn_d    = srcrdyn_q;
        frame_done_d = 1'b0;
        len_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (cmd_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        flag_d    = cmd_flag;
                        len_d     = cmd_len;
                        words_d   = words_of(cmd_len);
                        first_d   = 1'b1;
                        hdr_cnt_d = 4'd1;
                        txd_d     = 32'h0000_0000;
                        rem_d     = 4'b0000;
                        sofn_d    = 1'b0;
                        eofn_d    = 1'b1;
                        sopn_d    = 1'b1;
                        eopn_d    = 1'b1;
                        srcrdyn_d = 1'b0;
                        state_d   = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (load) begin
                    sofn_d = 1'b1;
                    if (hdr_cnt_q == HDR_WORDS) begin
                        srcrdyn_d = 1'b1;
                        state_d   = S_PAYLOAD;
                    end else begin
                        txd_d     = hdr_word(hdr_cnt_q, flag_q, len_q);
                        srcrdyn_d = 1'b0;
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (load) begin
                    if (pl_acc) begin
                        txd_d     = pl_data;
                        srcrdyn_d = 1'b0;
                        sopn_d    = ~first_q;
                        first_d   = 1'b0;
                        eopn_d    = ~last_word;
                        eofn_d    = ~last_word;
                        rem_d     = last_word ? rem_of(len_q[1:0]) : 4'b0000;
                        words_d   = words_q - LEN_W'(1);
                    end else begin
                        srcrdyn_d = 1'b1;
                        sopn_d    = 1'b1;
                        eopn_d    = 1'b1;
                        eofn_d    = 1'b1;
                        rem_d     = 4'b0000;
                    end
                end
                if (beat && words_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CPMDMALLCLK) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hdr_cnt_q    <= 4'd0;
            words_q      <= '0;
            first_q      <= 1'b0;
            txd_q        <= 32'h0000_0000;
            rem_q        <= 4'b0000;
            sofn_q       <= 1'b1;
            eofn_q       <= 1'b1;
            sopn_q       <= 1'b1;
            eopn_q       <= 1'b1;
            srcrdyn_q    <= 1'b1;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            words_q      <= words_d;
            first_q      <= first_d;
            txd_q        <= txd_d;
            rem_q        <= rem_d;
            sofn_q       <= sofn_d;
            eofn_q       <= eofn_d;
            sopn_q       <= sopn_d;
            eopn_q       <= eopn_d;
            srcrdyn_q    <= srcrdyn_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
        end
    end

    // Command fields are only meaningful while a frame is in flight.
    always_ff @(posedge CPMDMALLCLK) begin
        flag_q <= flag_d;
        len_q  <= len_d;
    end

    assign DMALLTXD       = txd_q;
    assign DMALLTXREM     = rem_q;
    assign DMALLTXSOFN    = sofn_q;
    assign DMALLTXEOFN    = eofn_q;
    assign DMALLTXSOPN    = sopn_q;
    assign DMALLTXEOPN    = eopn_q;
    assign DMALLTXSRCRDYN = srcrdyn_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = frame_done_q;
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_ll_tx_src.sv
// Bench for ll_tx_src: table of frame commands with hand-computed framing,
// plus directed sequences for zero length and mid-frame reset.
`timescale 1ns/1ps
module tb_ll_tx_src;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_flag = '0;
    logic [15:0] cmd_len = '0;
    logic [31:0] pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [31:0] txd;
    logic [3:0]  rem;
    logic        sofn, eofn, sopn, eopn, srcrdyn;
    logic        dstrdyn = 1'b0;
    logic        busy, frame_done, len_err;

    always #5 clk = ~clk;

    ll_tx_src #(.LEN_W(16)) dut (
        .CPMDMALLCLK      (clk),
        .DMALLRSTENGINEACK(rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_flag         (cmd_flag),
        .cmd_len          (cmd_len),
        .pl_data          (pl_data),
        .pl_valid         (pl_valid),
        .pl_ready         (pl_ready),
        .DMALLTXD         (txd),
        .DMALLTXREM       (rem),
        .DMALLTXSOFN      (sofn),
        .DMALLTXEOFN      (eofn),
        .DMALLTXSOPN      (sopn),
        .DMALLTXEOPN      (eopn),
        .DMALLTXSRCRDYN   (srcrdyn),
        .LLDMATXDSTRDYN   (dstrdyn),
        .busy             (busy),
        .frame_done       (frame_done),
        .len_err          (len_err)
    );

    typedef struct {
        logic [15:0] len;
        logic [31:0] flag;
        bit          stall;
        bit          gaps;
        int          exp_words;
        logic [3:0]  exp_rem;
    } vec_t;

    // {txd, rem, sof, eof, sop, eop} with flags active-high
    typedef logic [39:0] beat_t;

    vec_t  vecs[10];
    beat_t cap[$];
    int    n_checks = 0;
    int    n_fail = 0;

    logic [31:0] p_txd;
    logic [3:0]  p_rem;
    logic [3:0]  p_fl;
    logic        p_stall = 1'b0;

    // Beat capture and stall-stability monitor
    always @(negedge clk) begin
        if (p_stall) begin
            n_checks++;
            if ({txd, rem, sofn, eofn, sopn, eopn} !== {p_txd, p_rem, p_fl}) begin
                n_fail++;
                $display("FAIL stall_hold t=%0t got=%h/%b/%b want=%h/%b/%b", $time,
                         txd, rem, {sofn, eofn, sopn, eopn}, p_txd, p_rem, p_fl);
            end
        end
        p_stall <= !rst && !srcrdyn && dstrdyn;
        p_txd   <= txd;
        p_rem   <= rem;
        p_fl    <= {sofn, eofn, sopn, eopn};
        if (!srcrdyn && !dstrdyn)
            cap.push_back({txd, rem, ~sofn, ~eofn, ~sopn, ~eopn});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pay(input int vi, input int j);
        return {8'hA0 + 8'(j), 8'(vi), 16'hC3C3 ^ 16'(j)};
    endfunction

    function automatic beat_t exp_beat(input vec_t v, input int k);
        logic [31:0] d;
        logic        last;
        if (k < 8) begin
            d = (k == 4) ? v.flag : (k == 5) ? {16'h0, v.len} : 32'h0;
            return {d, 4'b0000, 1'(k == 0), 1'b0, 1'b0, 1'b0};
        end
        last = (k - 8 == v.exp_words - 1);
        return {32'h0, (last ? v.exp_rem : 4'b0000), 1'b0, last, 1'(k == 8), last};
    endfunction

    task automatic run_frame(input vec_t v, input int vi);
        int  idx = 0;
        int  cyc = 0;
        bit  cmd_done = 0;
        bit  got_done = 0;
        beat_t e;
        cap.delete();
        while (!got_done && cyc < 1000) begin
            @(posedge clk); #1;
            cmd_valid = !cmd_done;
            cmd_flag  = v.flag;
            cmd_len   = v.len;
            pl_valid  = (idx < v.exp_words) && (v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            pl_data   = pay(vi, idx);
            dstrdyn   = v.stall ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (cmd_valid && cmd_ready) cmd_done = 1;
            if (pl_valid && pl_ready) idx++;
            if (frame_done) got_done = 1;
            cyc++;
        end
        check($sformatf("v%0d_frame_done_seen", vi), 64'(got_done), 64'd1);
        check($sformatf("v%0d_idle_at_done", vi), {busy, srcrdyn}, 2'b01);
        check($sformatf("v%0d_beat_count", vi), 64'(cap.size()), 64'(8 + v.exp_words));
        for (int k = 0; k < 8 + v.exp_words && k < cap.size(); k++) begin
            e = exp_beat(v, k);
            if (k >= 8) e[39:8] = pay(vi, k - 8);
            check($sformatf("v%0d_beat%0d", vi, k), 64'(cap[k]), 64'(e));
        end
        @(posedge clk); #1;
        cmd_valid = 0; pl_valid = 0; dstrdyn = 0;
        @(negedge clk);
        check($sformatf("v%0d_done_pulse_end", vi), 64'(frame_done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'd8,  32'h2000_0000, 1'b0, 1'b0, 2, 4'b0000};
        vecs[1] = '{16'd5,  32'h0000_1234, 1'b0, 1'b0, 2, 4'b0111};
        vecs[2] = '{16'd7,  32'h2000_0001, 1'b0, 1'b0, 2, 4'b0001};
        vecs[3] = '{16'd1,  32'h0000_0000, 1'b0, 1'b0, 1, 4'b0111};
        vecs[4] = '{16'd6,  32'h8000_0000, 1'b0, 1'b0, 2, 4'b0011};
        vecs[5] = '{16'd13, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 4'b0111};
        vecs[6] = '{16'd10, 32'h2000_0000, 1'b1, 1'b0, 3, 4'b0011};
        vecs[7] = '{16'd9,  32'h0F0F_0F0F, 1'b0, 1'b1, 3, 4'b0111};
        vecs[8] = '{16'd6,  32'h1111_2222, 1'b1, 1'b1, 2, 4'b0011};
        vecs[9] = '{16'd4,  32'h2000_0000, 1'b0, 1'b0, 1, 4'b0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {srcrdyn, sofn, eofn, sopn, eopn, busy, frame_done, len_err},
              8'b11111000);
        check("rst_txd_rem", {txd, rem}, 36'h0);
        check("rst_readies", {cmd_ready, pl_ready}, 2'b00);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

        // Zero-length command is dropped with an error pulse
        @(posedge clk); #1;
        cap.delete();
        cmd_valid = 1; cmd_len = 16'd0; cmd_flag = 32'hFFFF_FFFF;
        @(negedge clk);
        check("zlen_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1 cmd_valid = 0;
        @(negedge clk);
        check("zlen_err_pulse", {len_err, busy, srcrdyn}, 3'b101);
        @(negedge clk);
        check("zlen_err_clear", {len_err, busy}, 2'b00);
        repeat (3) @(negedge clk);
        check("zlen_no_beats", 64'(cap.size()), 64'd0);
        run_frame(vecs[9], 9);

        // Reset while header word 3 is presented
        @(posedge clk); #1;
        cap.delete();
        cmd_valid = 1; cmd_len = 16'd8; cmd_flag = 32'h2000_0000; dstrdyn = 0;
        @(negedge clk);
        check("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1 cmd_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_hdr3_presented", {cap.size() == 3, srcrdyn, sofn, busy}, 4'b1011);
        rst = 1;
        @(negedge clk);
        check("mid_rst_readies", {cmd_ready, pl_ready}, 2'b00);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("mid_rst_state", {srcrdyn, sofn, eofn, sopn, eopn, busy}, 6'b111110);
        check("mid_rst_txd_rem", {txd, rem}, 36'h0);
        run_frame(vecs[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
